uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
UART transmit serializer and the transmit-side counterpart of the receive FIFO path. It drains bytes from an upstream first-word-fall-through transmit FIFO and frames each byte as start, data LSB-first, optional parity and stop. Bit timing comes from the shared 16x-oversampling baud tick generator. It sits between the TX FIFO read port and the top-level serial output pin.

Parameters:
DBIT, 8, data bits per frame
SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
s_tick  input  1  baud oversampling tick, one clk wide, 16 per bit period
fifo_empty  input  1  TX FIFO empty flag
fifo_r_data  input  DBIT  TX FIFO head word, valid whenever fifo_empty=0 (fall-through)
fifo_rd  output  1  one-cycle pop strobe to the TX FIFO
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high whenever state != IDLE
tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset values (async): state=IDLE; tick counter s=0; bit counter n=0; shift register b=0; tx=1; fifo_rd=0; tx_busy=0; tx_done=0.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: tx=1. If fifo_empty=0 on an edge: latch fifo_r_data into b, s<=0, go to START, and assert fifo_rd for exactly that one cycle. s_tick is not required. No pop ever occurs while fifo_empty=1.
- START: tx=0. On each s_tick: if s==15 then s<=0, n<=0, go to DATA; else s<=s+1.
- DATA: tx=b[0]. On each s_tick with s==15: s<=0, b<=b>>1. If n==DBIT-1, go to PARITY (macro) or STOP; else n<=n+1. Otherwise s<=s+1 on s_tick.
- STOP: tx=1. On s_tick with s==SB_TICK-1: go to IDLE and pulse tx_done for one cycle. Otherwise s<=s+1 on s_tick.
- Counters advance only on s_tick; cycles without s_tick hold all state.
- tx is registered. It changes on the clk edge after the state or shift change: the first start-bit low appears one clk after the fifo_rd cycle.
- Frame duration is (1+DBIT)*16 + SB_TICK s_ticks, plus 16 with parity.
- Back-to-back: if the FIFO is non-empty when STOP completes, IDLE pops on the next clk edge, giving a minimum 1-clk idle gap between frames. There is no other inter-frame gap.
- fifo_r_data is sampled only in the pop cycle. Later FIFO changes do not affect the current frame.
- Counter widths: s is wide enough for max(16, SB_TICK)-1; n is clog2(DBIT) bits. No wrap beyond the terminal values.
- Reset mid-frame: tx returns to 1 immediately. The in-flight byte is discarded, already popped and not re-sent. No tx_done pulse.

Optional Feature:
UART_TX_PARITY_EN: when defined, DATA goes to PARITY instead of STOP.
- PARITY: tx = even parity (XOR of the DBIT data bits, computed at latch time and held in a register) for 16 s_ticks, then STOP.
- When undefined: no PARITY state, no parity register, and DATA goes directly to STOP.

Test Plan:
- Reset, then fifo_empty=1 for 500 clks with s_tick every 16 clks -> tx=1, fifo_rd=0, tx_busy=0 throughout.
- Single byte 0x55, s_tick every clk -> fifo_rd high 1 clk; tx bit periods of 16 clks each: 0,1,0,1,0,1,0,1,0,1; tx_done pulses once after 160 ticks; with UART_TX_PARITY_EN a parity period of 0 precedes stop and the total is 176 ticks.
- Bytes 0xA3, 0x0F queued back-to-back -> two frames, LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; exactly one clk of tx=1 between the first frame's stop end and the second frame's start; exactly 2 fifo_rd pulses.
- s_tick every 16 clks, byte 0x00, SB_TICK=32 -> 9 low bit periods of 256 clks each, stop high for 512 clks, tx_done 1 clk.
- Assert reset during DATA bit 4 of 0xFF -> tx=1 within the same cycle; state IDLE; no tx_done; with the FIFO empty afterwards, no further activity.
- UART_TX_PARITY_EN, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: read port of a first-word-fall-through TX FIFO.
// master = the transmit engine (pops), slave = the FIFO (presents head word).
interface uart_tx_engine_if #(
    parameter int DBIT = 8
);
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_r_data;
    logic            fifo_rd;

    modport master (input fifo_empty, input fifo_r_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_r_data, input fifo_rd);
endinterface

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART serializer draining a fall-through TX FIFO.
// Frame = start(0), DBIT data bits LSB first, optional even parity, stop(1).
// Bit timing from a 16x oversampling s_tick. tx lags the state by one clk.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit.
module uart_tx_engine #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    uart_tx_engine_if.master fifo,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_next;
    logic [S_W-1:0]  s, s_next;
    logic [N_W-1:0]  n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            tx_next, rd_next, done_next;
`ifdef UART_TX_PARITY_EN
    logic            p, p_next;
`endif

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            fifo.fifo_rd <= 1'b0;
            tx_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            p            <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            tx           <= tx_next;
            fifo.fifo_rd <= rd_next;
            tx_done      <= done_next;
`ifdef UART_TX_PARITY_EN
            p            <= p_next;
`endif
        end
    end

    // Next-state: frame sequencing; counters only move on s_tick.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
`ifdef UART_TX_PARITY_EN
        p_next     = p;
`endif
        case (state)
            IDLE: begin
                // The head word is only sampled here; later FIFO changes are ignored.
                if (!fifo.fifo_empty) begin
                    state_next = START;
                    s_next     = '0;
                    b_next     = fifo.fifo_r_data;
`ifdef UART_TX_PARITY_EN
                    p_next     = ^fifo.fifo_r_data;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_W'(15)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_W'(15)) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == S_W'(15)) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s == S_W'(SB_TICK - 1)) begin
                        s_next     = '0;
                        state_next = IDLE;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: line level of the current state, pop and done strobes.
    always_comb begin
        tx_next   = 1'b1;
        rd_next   = 1'b0;
        done_next = 1'b0;
        tx_busy   = (state != IDLE);
        case (state)
            IDLE:   rd_next = !fifo.fifo_empty;
            START:  tx_next = 1'b0;
            DATA:   tx_next = b[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = p;
`endif
            STOP:   done_next = s_tick && (s == S_W'(SB_TICK - 1));
            default: tx_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table vectors + random traffic against a tick-count
// frame model; a second instance covers SB_TICK=32 timing.
module tb_uart_tx_engine;
    localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB          = DBIT + 3;
    localparam int FRAME_TICKS = (1 + DBIT) * 16 + 16 + 16;
    localparam int EXP_T       = 176;
`else
    localparam int NB          = DBIT + 2;
    localparam int FRAME_TICKS = (1 + DBIT) * 16 + 16;
    localparam int EXP_T       = 160;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_tick = 1'b0;
    logic tx, tx_busy, tx_done, tx32, busy32, done32;

    uart_tx_engine_if #(.DBIT(DBIT)) fif ();
    uart_tx_engine_if #(.DBIT(DBIT)) fif32 ();

    uart_tx_engine #(.DBIT(DBIT), .SB_TICK(16)) u_dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo(fif),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done));

    uart_tx_engine #(.DBIT(DBIT), .SB_TICK(32)) u_dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo(fif32),
        .tx(tx32), .tx_busy(busy32), .tx_done(done32));

    always #5 clk = ~clk;

    typedef struct { logic [15:0] bits; int ticks; } frame_t;
    typedef struct { logic [7:0] data; int tick_per; int exp_ticks; logic exp_par; } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [7:0] q[$], q32[$];
    bit rd_seen = 0, rd32_seen = 0, rst_req = 1;
    int tick_per = 16, tick_cnt = 0;
    // reference model: frame position expressed as ticks elapsed since the pop
    bit m_busy = 0;
    int m_ticks = 0;
    logic [7:0] m_byte = '0;
    logic exp_tx = 1'b1, exp_rd = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    // line monitor
    int mon_ticks = 0;
    logic [15:0] mon_bits = '0;
    frame_t frames[$];
    int rd_cnt = 0, done_cnt = 0, gap_cnt = 0, last_gap = -1;
    bit gap_arm = 0;
    bit arm32 = 0, mon32 = 0, got_done32 = 0;
    int low32 = 0, high32 = 0, done32_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DBIT) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == DBIT + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        logic st;
        frame_t fr;
        @(negedge clk);
        chk("tx", tx, exp_tx);
        chk("fifo_rd", fif.fifo_rd, exp_rd);
        chk("tx_done", tx_done, exp_done);
        chk("tx_busy", tx_busy, exp_busy);
        if (fif.fifo_rd) rd_cnt++;
        if (tx_done) begin
            fr.bits = mon_bits; fr.ticks = mon_ticks;
            frames.push_back(fr);
            mon_ticks = 0; mon_bits = '0; done_cnt++;
            gap_arm = 1; gap_cnt = 0;
        end else if (gap_arm) begin
            if (tx) gap_cnt++;
            else begin last_gap = gap_cnt; gap_arm = 0; end
        end
        if (mon32) begin
            if (!tx32) low32++;
            else if (low32 > 0 && !got_done32) high32++;
            if (done32) begin done32_cnt++; got_done32 = 1; end
        end
        if (rd_seen) void'(q.pop_front());
        rd_seen = fif.fifo_rd;
        if (rd32_seen) void'(q32.pop_front());
        rd32_seen = fif32.fifo_rd;
        reset = rst_req;
        if (tick_per == 0) st = ($urandom_range(0, 3) == 0);
        else st = ((tick_cnt % tick_per) == tick_per - 1);
        tick_cnt++;
        s_tick = st;
        if (arm32 && st) begin q32.push_back(8'h00); arm32 = 0; end
        fif.fifo_empty    = (q.size() == 0);
        fif.fifo_r_data   = (q.size() == 0) ? 8'h00 : q[0];
        fif32.fifo_empty  = (q32.size() == 0);
        fif32.fifo_r_data = (q32.size() == 0) ? 8'h00 : q32[0];
        if (tx_busy && st) begin
            mon_ticks++;
            if (mon_ticks % 16 == 8 && mon_ticks / 16 < 16) mon_bits[mon_ticks / 16] = tx;
        end
        exp_tx = m_busy ? line_bit(m_byte, m_ticks / 16) : 1'b1;
        exp_rd = 1'b0; exp_done = 1'b0;
        if (reset) begin
            m_busy = 0; exp_tx = 1'b1;
        end else if (!m_busy) begin
            if (q.size() != 0) begin m_busy = 1; m_ticks = 0; m_byte = q[0]; exp_rd = 1'b1; end
        end else if (st) begin
            m_ticks++;
            if (m_ticks == FRAME_TICKS) begin m_busy = 0; exp_done = 1'b1; end
        end
        exp_busy = m_busy;
    endtask

    task automatic check_frame(input string name, input int idx, input logic [7:0] data);
        if (idx >= frames.size()) begin
            chk({name, "_seen"}, frames.size(), idx + 1);
        end else begin
            chk({name, "_data"}, frames[idx].bits[DBIT:1], data);
            chk({name, "_start"}, frames[idx].bits[0], 1'b0);
            chk({name, "_stop"}, frames[idx].bits[NB-1], 1'b1);
        end
    endtask

    vec_t vecs[5];
    logic [7:0] sent[$];

    initial begin
        int nf, rd0, pushed;
        vecs[0] = '{8'h55, 1, EXP_T, 1'b0};
        vecs[1] = '{8'h07, 1, EXP_T, 1'b1};
        vecs[2] = '{8'h03, 2, EXP_T, 1'b0};
        vecs[3] = '{8'h80, 3, EXP_T, 1'b1};
        vecs[4] = '{8'hC6, 1, EXP_T, 1'b0};
        fif.fifo_empty = 1'b1; fif.fifo_r_data = '0;
        fif32.fifo_empty = 1'b1; fif32.fifo_r_data = '0;

        // reset held, then idle line for 500 clks with slow ticks
        repeat (3) step();
        rst_req = 0;
        repeat (500) step();
        chk("idle_rd_cnt", rd_cnt, 0);
        chk("idle_done_cnt", done_cnt, 0);

        // table vectors: one frame each
        for (int i = 0; i < 5; i++) begin
            tick_per = vecs[i].tick_per;
            nf = frames.size(); rd0 = rd_cnt;
            q.push_back(vecs[i].data);
            for (int c = 0; c < 4000 && frames.size() == nf; c++) step();
            repeat (10) step();
            check_frame("vec", nf, vecs[i].data);
            if (frames.size() > nf) chk("vec_ticks", frames[nf].ticks, vecs[i].exp_ticks);
`ifdef UART_TX_PARITY_EN
            if (frames.size() > nf) chk("vec_parity", frames[nf].bits[DBIT+1], vecs[i].exp_par);
`endif
            chk("vec_rd_pulses", rd_cnt - rd0, 1);
        end

        // back-to-back frames: single idle clk between stop and next start
        tick_per = 1; nf = frames.size(); rd0 = rd_cnt; last_gap = -1;
        q.push_back(8'hA3); q.push_back(8'h0F);
        for (int c = 0; c < 2000 && frames.size() < nf + 2; c++) step();
        repeat (5) step();
        check_frame("b2b0", nf, 8'hA3);
        check_frame("b2b1", nf + 1, 8'h0F);
        chk("b2b_rd_pulses", rd_cnt - rd0, 2);
        chk("b2b_gap", last_gap, 1);

        // random bytes at random times with irregular ticks
        tick_per = 0; nf = frames.size(); pushed = 0;
        for (int c = 0; c < 30000 && frames.size() < nf + 8; c++) begin
            if (pushed < 8 && $urandom_range(0, 99) < 3) begin
                sent.push_back(8'($urandom)); q.push_back(sent[pushed]); pushed++;
            end
            step();
        end
        for (int i = 0; i < 8; i++) check_frame("rnd", nf + i, (i < pushed) ? sent[i] : 8'h00);

        // SB_TICK=32 instance, byte 0x00, tick every 16 clks
        tick_per = 16; mon32 = 1; arm32 = 1;
        for (int c = 0; c < 5000 && !got_done32; c++) step();
        repeat (50) step();
        chk("sb32_low_clks", low32, 2304);
        chk("sb32_stop_clks", high32, 512);
        chk("sb32_done_cnt", done32_cnt, 1);
        mon32 = 0;

        // reset during data bit 4 of 0xFF
        tick_per = 1; nf = frames.size(); rd0 = rd_cnt;
        q.push_back(8'hFF);
        for (int c = 0; c < 1000 && mon_ticks < 16 * 5 + 4; c++) step();
        chk("rst_busy_before", tx_busy, 1'b1);
        reset = 1'b1; rst_req = 1;
        #1;
        chk("rst_tx_now", tx, 1'b1);
        chk("rst_busy_now", tx_busy, 1'b0);
        m_busy = 0; exp_tx = 1'b1; exp_rd = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
        mon_ticks = 0; mon_bits = '0; rd_seen = 0; gap_arm = 0;
        repeat (2) step();
        rst_req = 0;
        repeat (300) step();
        chk("rst_no_done", frames.size(), nf);
        chk("rst_rd_cnt", rd_cnt - rd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
